txfifo_arb: RTL and testbench
=============================

# txfifo_arb

Round-robin, message-locked arbiter that shares the write port of one transmit `ufifo` among `NREQ` requesters (console, debug bus, status reporter, …) feeding a single UART transmitter. Once granted, a requester keeps the FIFO until it marks end-of-message, so messages never interleave. A watchdog reclaims the grant from a stalled owner. Sits between the requesters and the TX FIFO's `i_wr`/`i_data`/`o_status` ports.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `BW`, 8: data width; matches FIFO `BW`.
- `LGFLEN`, 4: FIFO log2 length; matches the FIFO instance.
- `TMO`, 1024: idle cycles allowed to a lock holder before forced release; ≥2.

Ports:
- `i_clk`  in  1  system clock.
- `i_rst`  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `i_req_stb`  in  NREQ  requester k offers a byte.
- `i_req_data`  in  NREQ*BW  byte for requester k in bits [k*BW +: BW].
- `i_req_last`  in  NREQ  offered byte ends requester k's message.
- `o_req_ack`  out  NREQ  combinational; byte from requester k accepted this cycle.
- `o_fifo_wr`  out  1  registered FIFO write strobe.
- `o_fifo_data`  out  BW  registered FIFO write data.
- `i_fifo_status`  in  16  TX FIFO status word; empty-slot count in bits [LGFLEN+1:2].
- `o_busy`  out  1  a requester holds the lock.
- `o_owner`  out  3  index of current or last owner.
- `o_tmo_err`  out  NREQ  sticky per-requester timeout flag.
- `i_tmo_clr`  in  NREQ  clears the matching `o_tmo_err` bits.

## Operation
- **States:** IDLE, LOCK.
- **IDLE:**
  - Search `i_req_stb` starting at index `rr_ptr` and wrapping modulo `NREQ`.
  - The first set bit becomes the owner: register `o_owner`, go to LOCK, `o_busy`=1.
  - No ack is issued in IDLE.
- **LOCK:**
  - `space` = status empty-slot field. `o_req_ack[owner]` = `i_req_stb[owner]` && (`space` > `o_fifo_wr`).
  - The `> o_fifo_wr` term accounts for a write registered but not yet reflected in status.
  - On ack: next cycle `o_fifo_wr`=1 and `o_fifo_data` = owner's byte. Otherwise `o_fifo_wr`=0 and `o_fifo_data` holds its value.
  - Non-owner strobes are never acked; their requesters hold data and strobe.
  - Ack with `i_req_last`: go to IDLE, `rr_ptr` = owner+1 mod `NREQ`, `o_busy`=0.
- **Watchdog:**
  - Counter clears on IDLE→LOCK and on every ack.
  - It increments on each LOCK cycle without an ack.
  - When it reaches `TMO`-1 with no ack that cycle: set `o_tmo_err[owner]`, release as if `last` were seen, advance `rr_ptr`.
  - FIFO-full stalls count toward the timeout only if `space` ≠ 0. A full FIFO stalls the owner without penalty.
- **`o_tmo_err`:** set has priority over `i_tmo_clr` in the same cycle.
- **Reset values:**
  - State IDLE, `rr_ptr`=0, counter=0.
  - `o_fifo_wr`=0, `o_fifo_data`=0, `o_busy`=0, `o_owner`=0, `o_tmo_err`=0.
- **Mid-message reset:** the lock is dropped and no partial-byte write is issued after reset.

## Timing
- Arbitration: 1 cycle (IDLE→LOCK). The first ack is possible on the first LOCK cycle.
- Throughput: one byte per cycle while `space` allows.
- Ack-to-write latency: 1 cycle.
- After releasing, at least one IDLE cycle before the next grant. That cycle may regrant the same requester only if no other requester is pending.
- Simultaneous ack+`last` and a new request elsewhere: the new requester is granted on the following IDLE cycle.
- Last free slot: with `space`=1 and `o_fifo_wr`=1, ack is withheld, so the FIFO never overflows and its `o_err` stays low.
- Counter width: clog2(`TMO`). No wrap is possible because release occurs at `TMO`-1.

## Structure
- **Shared package `txfifo_arb_pkg`:** state enum (IDLE, LOCK), `fill_field(status, LGFLEN)` extraction helper, default `TMO`.
- **Sub-module `rr_pick`:** combinational round-robin first-set search from a pointer. It returns a valid flag and an index. It is reusable by the RX side.

## Test plan
- Reset, then requester 2 sends 3 bytes 0x41, 0x42, 0x43 with `last` on 0x43 into an empty 16-deep FIFO → 1 arbitration cycle, then acks on 3 consecutive cycles; `o_fifo_wr` pulses 3 cycles, one cycle later; `o_busy` falls after the third ack.
- Requesters 0 and 1 both strobe 2-byte messages from reset → req0 message completes before any req1 ack; next arbitration grants 1; then with both pending again, 1→2 order is honored (`rr_ptr`=2 picks 0 only after 2, 3 are idle).
- FIFO 15 of 16 slots full (`space`=1), owner sends 4 bytes → exactly 1 write; ack held low until status shows `space` increasing; no FIFO overflow.
- Owner 3 is granted then drops `i_req_stb` → after `TMO`-1 idle cycles `o_tmo_err[3]`=1, `o_busy`=0, requester 0 is granted next; `i_tmo_clr[3]` clears the flag.
- Assert `i_rst` during the 2nd byte of a 5-byte message → next cycle all outputs are at reset values, no further `o_fifo_wr`, and arbitration restarts from index 0.

Source files
------------

// File: rtl/txfifo_arb_pkg.sv
// Shared definitions for the TX FIFO write-port arbiter.
package txfifo_arb_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    localparam int TMO_DEFAULT = 1024;

    // Empty-slot count lives in status bits [lgflen+1:2].
    function automatic logic [15:0] fill_field(input logic [15:0] status, input int lgflen);
        logic [15:0] mask;
        mask = (16'd1 << lgflen) - 16'd1;
        return (status >> 2) & mask;
    endfunction

endpackage

// File: rtl/txfifo_arb_rr_pick.sv
// Combinational round-robin first-set search starting at a pointer.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] i_req,
    input  logic [2:0]   i_ptr,
    output logic         o_valid,
    output logic [2:0]   o_idx
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    // Walk offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        logic [IW-1:0] j;
        j       = '0;
        o_valid = 1'b0;
        o_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            j = IW'((int'(i_ptr) + i) % N);
            if (i_req[j]) begin
                o_valid = 1'b1;
                o_idx   = 3'(j);
            end
        end
    end

endmodule

// File: rtl/txfifo_arb.sv
// Round-robin, message-locked arbiter for the write port of one TX FIFO.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no owner; search requests from rr_ptr, grant takes 1 cycle
// LOCK    | owner may write bytes until last or watchdog release
module txfifo_arb
    import txfifo_arb_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int BW     = 8,
    parameter int LGFLEN = 4,
    parameter int TMO    = TMO_DEFAULT
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NREQ-1:0]    i_req_stb,
    input  logic [NREQ*BW-1:0] i_req_data,
    input  logic [NREQ-1:0]    i_req_last,
    output logic [NREQ-1:0]    o_req_ack,
    output logic               o_fifo_wr,
    output logic [BW-1:0]      o_fifo_data,
    input  logic [15:0]        i_fifo_status,
    output logic               o_busy,
    output logic [2:0]         o_owner,
    output logic [NREQ-1:0]    o_tmo_err,
    input  logic [NREQ-1:0]    i_tmo_clr
);

    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TMO);

    logic [0:0]      state;
    logic [2:0]      rr_ptr;
    logic [CW-1:0]   tmo_cnt;
    logic [OW-1:0]   own;
    logic [15:0]     space;
    logic            ack;
    logic            own_last;
    logic [BW-1:0]   own_data;
    logic            tmo_hit;
    logic            rel;
    logic [2:0]      next_ptr;
    logic            pick_valid;
    logic [2:0]      pick_idx;
    logic [NREQ-1:0] tmo_set;

    assign own      = o_owner[OW-1:0];
    assign space    = fill_field(i_fifo_status, LGFLEN);
    assign own_last = i_req_last[own];
    assign own_data = i_req_data[own*BW +: BW];
    assign o_busy   = (state == ST_LOCK);

    // A registered write not yet visible in status still occupies a slot.
    assign ack      = (state == ST_LOCK) && i_req_stb[own] && (space > {15'd0, o_fifo_wr});
    assign tmo_hit  = (state == ST_LOCK) && !ack && (space != 16'd0)
                      && (tmo_cnt == CW'(TMO - 1));
    assign rel      = (state == ST_LOCK) && ((ack && own_last) || tmo_hit);
    assign next_ptr = (o_owner == 3'(NREQ - 1)) ? 3'd0 : o_owner + 3'd1;

    rr_pick #(
        .N(NREQ)
    ) u_pick (
        .i_req   (i_req_stb),
        .i_ptr   (rr_ptr),
        .o_valid (pick_valid),
        .o_idx   (pick_idx)
    );

    // Only the owner can be acknowledged.
    always_comb begin
        o_req_ack      = '0;
        o_req_ack[own] = ack;
    end

    // Timeout flag for the owner being reclaimed.
    always_comb begin
        tmo_set = '0;
        if (tmo_hit) begin
            tmo_set[own] = 1'b1;
        end
    end

    // FIFO write port and sticky timeout flags; a new timeout beats a clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_fifo_wr   <= 1'b0;
            o_fifo_data <= '0;
            o_tmo_err   <= '0;
        end else begin
            o_fifo_wr <= ack;
            if (ack) begin
                o_fifo_data <= own_data;
            end
            o_tmo_err <= (o_tmo_err & ~i_tmo_clr) | tmo_set;
        end
    end

    // Grant/release FSM with the idle-owner watchdog.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            rr_ptr  <= 3'd0;
            tmo_cnt <= '0;
            o_owner <= 3'd0;
        end else if (state == ST_IDLE) begin
            tmo_cnt <= '0;
            if (pick_valid) begin
                o_owner <= pick_idx;
                state   <= ST_LOCK;
            end
        end else begin
            if (rel) begin
                state   <= ST_IDLE;
                rr_ptr  <= next_ptr;
                tmo_cnt <= '0;
            end else if (ack) begin
                tmo_cnt <= '0;
            end else if (space != 16'd0) begin
                // A full FIFO stalls the owner without counting against it.
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_txfifo_arb.sv
// Directed bench for txfifo_arb with a byte scoreboard on the FIFO write port.
module tb_txfifo_arb;

    localparam int NREQ   = 4;
    localparam int BW     = 8;
    localparam int LGFLEN = 4;
    localparam int TMO    = 1024;

    logic               i_clk = 1'b0;
    logic               i_rst = 1'b1;
    logic [NREQ-1:0]    i_req_stb = '0;
    logic [NREQ*BW-1:0] i_req_data = '0;
    logic [NREQ-1:0]    i_req_last = '0;
    logic [NREQ-1:0]    o_req_ack;
    logic               o_fifo_wr;
    logic [BW-1:0]      o_fifo_data;
    logic [15:0]        i_fifo_status = 16'h003C;
    logic               o_busy;
    logic [2:0]         o_owner;
    logic [NREQ-1:0]    o_tmo_err;
    logic [NREQ-1:0]    i_tmo_clr = '0;

    txfifo_arb #(
        .NREQ(NREQ), .BW(BW), .LGFLEN(LGFLEN), .TMO(TMO)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_req_stb     (i_req_stb),
        .i_req_data    (i_req_data),
        .i_req_last    (i_req_last),
        .o_req_ack     (o_req_ack),
        .o_fifo_wr     (o_fifo_wr),
        .o_fifo_data   (o_fifo_data),
        .i_fifo_status (i_fifo_status),
        .o_busy        (o_busy),
        .o_owner       (o_owner),
        .o_tmo_err     (o_tmo_err),
        .i_tmo_clr     (i_tmo_clr)
    );

    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int wr_cnt  = 0;
    int wr0;
    int n;

    logic [8:0]      src_q [NREQ][$];
    logic [NREQ-1:0] en = '1;
    logic [7:0]      exp_data [$];
    int              exp_cyc [$];
    int              ack_req [$];
    int              ack_cyc [$];

    always @(posedge i_clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard sink: every FIFO write must match the oldest accepted byte, one cycle later.
    always @(negedge i_clk) begin
        if (o_fifo_wr === 1'b1) begin
            wr_cnt++;
            check("write_expected", 32'(exp_data.size() != 0), 1);
            if (exp_data.size() != 0) begin
                check("wr_data", 32'(o_fifo_data), 32'(exp_data.pop_front()));
                check("wr_latency", cyc, exp_cyc.pop_front() + 1);
            end
        end
    end

    task automatic drive();
        logic [8:0] e;
        for (int k = 0; k < NREQ; k++) begin
            if (en[k] && src_q[k].size() > 0) begin
                e = src_q[k][0];
                i_req_stb[k] = 1'b1;
                i_req_data[k*BW +: BW] = e[7:0];
                i_req_last[k] = e[8];
            end else begin
                i_req_stb[k]  = 1'b0;
                i_req_last[k] = 1'b0;
            end
        end
    endtask

    // One clock: sample acks mid-cycle, then drive the next offers after the edge.
    task automatic step();
        logic [8:0] e;
        @(negedge i_clk);
        check("ack_onehot", 32'($onehot0(o_req_ack)), 1);
        if (!i_rst) begin
            for (int k = 0; k < NREQ; k++) begin
                if (o_req_ack[k] && src_q[k].size() > 0) begin
                    e = src_q[k].pop_front();
                    exp_data.push_back(e[7:0]);
                    exp_cyc.push_back(cyc);
                    ack_req.push_back(k);
                    ack_cyc.push_back(cyc);
                end
            end
        end
        @(posedge i_clk);
        #1;
        drive();
    endtask

    task automatic clear_src();
        for (int k = 0; k < NREQ; k++) src_q[k].delete();
    endtask

    task automatic clear_log();
        ack_req.delete();
        ack_cyc.delete();
    endtask

    task automatic wait_acks(input int cnt, input int budget, input string tag);
        int b;
        b = 0;
        while (ack_req.size() < cnt && b < budget) begin
            step();
            b++;
        end
        check({tag, "_ack_timeout"}, 32'(ack_req.size() >= cnt), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr"},    32'(o_fifo_wr), 0);
        check({tag, "_data"},  32'(o_fifo_data), 0);
        check({tag, "_busy"},  32'(o_busy), 0);
        check({tag, "_owner"}, 32'(o_owner), 0);
        check({tag, "_err"},   32'(o_tmo_err), 0);
    endtask

    task automatic apply_reset();
        i_rst = 1'b1;
        clear_src();
        step();
        step();
        i_rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        // Reset state
        apply_reset();
        check_reset_outputs("reset");

        // Requester 2 sends a 3-byte message into an empty FIFO
        clear_log();
        src_q[2].push_back(9'h041);
        src_q[2].push_back(9'h042);
        src_q[2].push_back(9'h143);
        wr0 = wr_cnt;
        n = cyc;
        drive();
        wait_acks(3, 20, "t1");
        check("t1_arb_latency", ack_cyc[0], n + 1);
        check("t1_ack1_consec", ack_cyc[1], ack_cyc[0] + 1);
        check("t1_ack2_consec", ack_cyc[2], ack_cyc[0] + 2);
        check("t1_req", ack_req[2], 2);
        check("t1_busy_fall", 32'(o_busy), 0);
        step();
        check("t1_writes", wr_cnt - wr0, 3);
        check("t1_wr_low", 32'(o_fifo_wr), 0);

        // Requesters 0 and 1 from reset, then round-robin order from rr_ptr=2
        apply_reset();
        clear_log();
        src_q[0].push_back(9'h010);
        src_q[0].push_back(9'h111);
        src_q[1].push_back(9'h020);
        src_q[1].push_back(9'h121);
        drive();
        wait_acks(4, 30, "t2a");
        check("t2a_order0", ack_req[0], 0);
        check("t2a_order1", ack_req[1], 0);
        check("t2a_order2", ack_req[2], 1);
        check("t2a_order3", ack_req[3], 1);
        clear_log();
        src_q[0].push_back(9'h130);
        src_q[2].push_back(9'h150);
        src_q[3].push_back(9'h160);
        drive();
        wait_acks(3, 30, "t2b");
        check("t2b_order0", ack_req[0], 2);
        check("t2b_order1", ack_req[1], 3);
        check("t2b_order2", ack_req[2], 0);
        step();
        step();

        // Last free slot: ack withheld while a write is still in flight
        i_fifo_status = 16'h0004;
        clear_log();
        wr0 = wr_cnt;
        src_q[1].push_back(9'h070);
        src_q[1].push_back(9'h071);
        src_q[1].push_back(9'h072);
        src_q[1].push_back(9'h173);
        drive();
        wait_acks(1, 10, "t3");
        #1;
        check("t3_wr_inflight", 32'(o_fifo_wr), 1);
        check("t3_ack_withheld", 32'(o_req_ack), 0);
        i_fifo_status = 16'h0000;
        for (int i = 0; i < 10; i++) step();
        check("t3_single_ack", ack_req.size(), 1);
        check("t3_single_write", wr_cnt - wr0, 1);
        check("t3_still_busy", 32'(o_busy), 1);
        i_fifo_status = 16'h000C;
        wait_acks(4, 20, "t3b");
        check("t3_resume_consec", ack_cyc[3], ack_cyc[1] + 2);
        step();
        step();
        check("t3_total_writes", wr_cnt - wr0, 4);
        i_fifo_status = 16'h003C;

        // Owner 3 stalls; watchdog reclaims and requester 0 follows
        clear_log();
        src_q[3].push_back(9'h1AA);
        drive();
        en[3] = 1'b0;
        step();
        check("t4_busy", 32'(o_busy), 1);
        check("t4_owner3", 32'(o_owner), 3);
        src_q[0].push_back(9'h1BB);
        drive();
        n = 0;
        while (o_busy && n < TMO + 10) begin
            step();
            n++;
        end
        check("t4_tmo_cycles", n, TMO);
        check("t4_tmo_err", 32'(o_tmo_err), 32'h8);
        check("t4_no_ack", ack_req.size(), 0);
        step();
        check("t4_regrant_busy", 32'(o_busy), 1);
        check("t4_regrant_owner", 32'(o_owner), 0);
        wait_acks(1, 5, "t4");
        check("t4_req0_ack", ack_req[0], 0);
        i_tmo_clr = 4'b1000;
        step();
        i_tmo_clr = '0;
        check("t4_err_cleared", 32'(o_tmo_err), 0);
        src_q[3].delete();
        en[3] = 1'b1;
        step();

        // Reset in the middle of a 5-byte message
        clear_log();
        for (int i = 0; i < 5; i++) src_q[1].push_back({(i == 4), 8'(8'h80 + i)});
        drive();
        wait_acks(1, 10, "t5");
        i_rst = 1'b1;
        step();
        check_reset_outputs("t5_rst");
        clear_src();
        i_rst = 1'b0;
        drive();
        wr0 = wr_cnt;
        for (int i = 0; i < 4; i++) step();
        check("t5_no_write", wr_cnt - wr0, 0);
        clear_log();
        src_q[0].push_back(9'h190);
        src_q[1].push_back(9'h191);
        drive();
        wait_acks(2, 20, "t5b");
        check("t5_restart0", ack_req[0], 0);
        check("t5_restart1", ack_req[1], 1);

        step();
        step();
        check("scoreboard_drained", exp_data.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
